// File: rtl/match_packet_buffer.sv
// Match-filtered packet store: a packet is held in full and forwarded only
// when its eop tag reports a match and it fit in the store. Speculative
// writes are rolled back to the committed pointer on drop/abort/no-match.
//
// Handshake: an output beat transfers on a rising edge where
// valid_out & ready_in; while valid_out & !ready_in every output field is
// held. The input side has no backpressure: valid_in words are always consumed.
module match_packet_buffer #(
   parameter int DEPTH = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk_host,
   input  logic             rst_n,
   input  logic             valid_in,
   input  logic             sop_in,
   input  logic             eop_in,
   input  logic [2:0]       length_in,
   input  logic [63:0]      data_in,
   input  logic [7:0]       buffer_in,
   output logic             valid_out,
   output logic             sop_out,
   output logic             eop_out,
   output logic [63:0]      data_out,
   output logic [2:0]       length_out,
   output logic [7:0]       match_id_out,
   input  logic             ready_in,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] nomatch_cnt,
   output logic [CNT_W-1:0] ovf_cnt,
   output logic [CNT_W-1:0] proto_err_cnt,
   output logic [1:0]       wr_state_dbg
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_RECV = 2'd1,
      W_DROP = 2'd2
   } w_state_t;

   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  len;
      logic        sop;
      logic        eop;
      logic [7:0]  tag;
   } word_t;

   word_t         mem [0:DEPTH-1];
   w_state_t      w_state;
   logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
   logic [PW-1:0] wp, occ;
   logic          accept, full, do_write;
   logic          avail, out_adv, s1_load, s1_vld;
   word_t         in_word, s1_word;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign wr_state_dbg = w_state;

   // Write-side decode: a sop word always restarts at the committed pointer.
   always_comb begin
      accept       = valid_in & (sop_in | (w_state == W_RECV));
      wp           = sop_in ? cm_ptr : wr_ptr;
      occ          = wp - rd_ptr;
      full         = (occ == PW'(DEPTH));
      do_write     = accept & ~full;
      in_word.data = data_in;
      in_word.len  = eop_in ? length_in : 3'd7;
      in_word.sop  = sop_in;
      in_word.eop  = eop_in;
      in_word.tag  = eop_in ? buffer_in : 8'd0;
      avail        = (rd_ptr != cm_ptr);
      out_adv      = ~valid_out | ready_in;
      s1_load      = avail & (~s1_vld | out_adv);
   end

   // Packet store write port.
   always_ff @(posedge clk_host) begin
      if (do_write) mem[wp[AW-1:0]] <= in_word;
   end

   // Write FSM: speculative pointer, commit/rollback and statistics.
   always_ff @(posedge clk_host or negedge rst_n) begin
      if (!rst_n) begin
         w_state       <= W_IDLE;
         wr_ptr        <= '0;
         cm_ptr        <= '0;
         pass_cnt      <= '0;
         nomatch_cnt   <= '0;
         ovf_cnt       <= '0;
         proto_err_cnt <= '0;
      end else if (valid_in) begin
         // sop inside a packet aborts it; a headless word in idle is stray.
         if ((sop_in && w_state != W_IDLE) || (!sop_in && w_state == W_IDLE))
            proto_err_cnt <= sat_inc(proto_err_cnt);
         if (accept) begin
            if (full) begin
               wr_ptr <= cm_ptr;
               if (eop_in) begin
                  ovf_cnt <= sat_inc(ovf_cnt);
                  w_state <= W_IDLE;
               end else begin
                  w_state <= W_DROP;
               end
            end else if (eop_in) begin
               if (buffer_in != 8'd0) begin
                  wr_ptr   <= wp + PW'(1);
                  cm_ptr   <= wp + PW'(1);
                  pass_cnt <= sat_inc(pass_cnt);
               end else begin
                  wr_ptr      <= cm_ptr;
                  nomatch_cnt <= sat_inc(nomatch_cnt);
               end
               w_state <= W_IDLE;
            end else begin
               wr_ptr  <= wp + PW'(1);
               w_state <= W_RECV;
            end
         end else if (w_state == W_DROP && eop_in) begin
            ovf_cnt <= sat_inc(ovf_cnt);
            w_state <= W_IDLE;
         end
      end
   end

   // Read stage data: registered fetch of the word at rd_ptr.
   always_ff @(posedge clk_host) begin
      if (s1_load) s1_word <= mem[rd_ptr[AW-1:0]];
   end

   // Read stage control and output register; output holds while stalled.
   always_ff @(posedge clk_host or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr       <= '0;
         s1_vld       <= 1'b0;
         valid_out    <= 1'b0;
         sop_out      <= 1'b0;
         eop_out      <= 1'b0;
         data_out     <= '0;
         length_out   <= '0;
         match_id_out <= '0;
      end else begin
         if (s1_load) begin
            s1_vld <= 1'b1;
            rd_ptr <= rd_ptr + PW'(1);
         end else if (out_adv) begin
            s1_vld <= 1'b0;
         end
         if (out_adv) begin
            valid_out    <= s1_vld;
            sop_out      <= s1_vld & s1_word.sop;
            eop_out      <= s1_vld & s1_word.eop;
            data_out     <= s1_vld ? s1_word.data : 64'd0;
            length_out   <= s1_vld ? s1_word.len : 3'd0;
            match_id_out <= s1_vld ? s1_word.tag : 8'd0;
         end
      end
   end
endmodule

// File: tb/tb_match_packet_buffer.sv
// Bench for match_packet_buffer: directed packets, a packet-level reference
// model with an expected-beat queue, and per-cycle output/counter checks.
module tb_match_packet_buffer;
   localparam int DEPTH = 64;
   localparam int CNT_W = 16;
   localparam int BW    = 77;

   logic             clk_host  = 1'b0;
   logic             rst_n     = 1'b1;
   logic             valid_in  = 1'b0;
   logic             sop_in    = 1'b0;
   logic             eop_in    = 1'b0;
   logic [2:0]       length_in = 3'd0;
   logic [63:0]      data_in   = 64'd0;
   logic [7:0]       buffer_in = 8'd0;
   logic             ready_in  = 1'b1;
   logic             valid_out, sop_out, eop_out;
   logic [63:0]      data_out;
   logic [2:0]       length_out;
   logic [7:0]       match_id_out;
   logic [CNT_W-1:0] pass_cnt, nomatch_cnt, ovf_cnt, proto_err_cnt;
   logic [1:0]       wr_state_dbg;

   logic             s_valid, s_sop, s_eop;
   logic [63:0]      s_data;
   logic [2:0]       s_len;
   logic [7:0]       s_mid;
   logic [1:0]       s_pass, s_nom, s_ovf, s_proto, s_dbg;

   int total = 0, bad = 0, cyc = 0, rdy_mode = 0;

   logic [BW-1:0] exp_q[$];
   int            exp_cyc[$];
   logic [BW-1:0] cur[$];
   bit            m_in_pkt = 0, m_drop = 0;
   int            m_pass = 0, m_nom = 0, m_ovf = 0, m_proto = 0;

   match_packet_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
      .clk_host(clk_host), .rst_n(rst_n), .valid_in(valid_in), .sop_in(sop_in),
      .eop_in(eop_in), .length_in(length_in), .data_in(data_in), .buffer_in(buffer_in),
      .valid_out(valid_out), .sop_out(sop_out), .eop_out(eop_out), .data_out(data_out),
      .length_out(length_out), .match_id_out(match_id_out), .ready_in(ready_in),
      .pass_cnt(pass_cnt), .nomatch_cnt(nomatch_cnt), .ovf_cnt(ovf_cnt),
      .proto_err_cnt(proto_err_cnt), .wr_state_dbg(wr_state_dbg));

   // Narrow-counter instance, used only to observe saturation.
   match_packet_buffer #(.DEPTH(4), .CNT_W(2)) u_small (
      .clk_host(clk_host), .rst_n(rst_n), .valid_in(valid_in), .sop_in(sop_in),
      .eop_in(eop_in), .length_in(length_in), .data_in(data_in), .buffer_in(buffer_in),
      .valid_out(s_valid), .sop_out(s_sop), .eop_out(s_eop), .data_out(s_data),
      .length_out(s_len), .match_id_out(s_mid), .ready_in(ready_in),
      .pass_cnt(s_pass), .nomatch_cnt(s_nom), .ovf_cnt(s_ovf),
      .proto_err_cnt(s_proto), .wr_state_dbg(s_dbg));

   // Clock / ready generation
   always #5 clk_host = ~clk_host;

   always @(posedge clk_host) begin
      #1;
      case (rdy_mode)
         0:       ready_in = 1'b1;
         1:       ready_in = 1'b0;
         default: ready_in = ~ready_in;
      endcase
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference model: packet-level rules. Overflow is modelled as the
   // packet outgrowing DEPTH; stimulus only sends long packets into an
   // otherwise empty store.
   always @(posedge clk_host) begin
      logic [BW-1:0] beat;
      cyc++;
      if (!rst_n) begin
         m_in_pkt = 0; m_drop = 0;
         cur.delete(); exp_q.delete(); exp_cyc.delete();
         m_pass = 0; m_nom = 0; m_ovf = 0; m_proto = 0;
      end else if (valid_in) begin
         beat = {data_in, eop_in ? length_in : 3'd7, sop_in, eop_in, eop_in ? buffer_in : 8'd0};
         if (sop_in) begin
            if (m_in_pkt || m_drop) m_proto++;
            cur.delete();
            m_drop = 0;
            m_in_pkt = 1;
         end
         if (m_in_pkt) begin
            if (cur.size() == DEPTH) begin
               cur.delete();
               m_in_pkt = 0;
               if (eop_in) m_ovf++;
               else m_drop = 1;
            end else begin
               cur.push_back(beat);
               if (eop_in) begin
                  if (buffer_in != 8'd0) begin
                     foreach (cur[i]) begin
                        exp_q.push_back(cur[i]);
                        exp_cyc.push_back(cyc);
                     end
                     m_pass++;
                  end else begin
                     m_nom++;
                  end
                  cur.delete();
                  m_in_pkt = 0;
               end
            end
         end else if (m_drop) begin
            if (eop_in) begin
               m_ovf++;
               m_drop = 0;
            end
         end else begin
            m_proto++;
         end
      end
   end

   // Scoreboard / compare, sampled mid-cycle.
   logic [BW:0] held;
   bit          hold_pend = 0;
   always @(negedge clk_host) begin
      logic [BW-1:0] act, e;
      if (!rst_n) begin
         chk("reset_valid_out", 128'(valid_out), 128'(0));
         hold_pend = 0;
      end else begin
         chk("pass_cnt", 128'(pass_cnt), 128'(m_pass));
         chk("nomatch_cnt", 128'(nomatch_cnt), 128'(m_nom));
         chk("ovf_cnt", 128'(ovf_cnt), 128'(m_ovf));
         chk("proto_err_cnt", 128'(proto_err_cnt), 128'(m_proto));
         act = {data_out, length_out, sop_out, eop_out, match_id_out};
         if (hold_pend) chk("stall_hold", 128'({valid_out, act}), 128'(held));
         if (exp_q.size() > 0 && cyc >= exp_cyc[0] + 2)
            chk("beat_due", 128'(valid_out), 128'(1));
         if (valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_beat: got %0h want none", act);
            end else begin
               e = exp_q.pop_front();
               void'(exp_cyc.pop_front());
               chk("beat", 128'(act), 128'(e));
            end
         end else if (!valid_out) begin
            chk("idle_match_id", 128'(match_id_out), 128'(0));
         end
         hold_pend = valid_out && !ready_in;
         held = {valid_out, act};
      end
   end

   // Driver tasks
   task automatic drive(input logic sop, input logic eop, input logic [2:0] len,
                        input logic [63:0] d, input logic [7:0] tag);
      valid_in = 1'b1; sop_in = sop; eop_in = eop;
      length_in = len; data_in = d; buffer_in = tag;
      @(posedge clk_host); #1;
      valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0; buffer_in = 8'hEE;
   endtask

   task automatic send_pkt(input int id, input int n, input logic [7:0] tag,
                           input logic [2:0] len, input bit lat_chk);
      for (int i = 0; i < n; i++)
         drive(i == 0, i == n - 1, len, {8'hD0, 8'(id), 16'h0, 32'(i * 3 + 1)}, tag);
      if (lat_chk) begin
         chk("lat_edge0", 128'(valid_out), 128'(0));
         @(posedge clk_host); #1;
         chk("lat_edge1", 128'(valid_out), 128'(0));
         @(posedge clk_host); #1;
         chk("lat_edge2_valid", 128'(valid_out), 128'(1));
         chk("lat_edge2_sop", 128'(sop_out), 128'(1));
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_host);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      wait_cyc(2);
      rst_n = 1'b1;
      chk("rst_valid_out", 128'(valid_out), 128'(0));
      chk("rst_state", 128'(wr_state_dbg), 128'(0));
      chk("rst_counters", 128'({pass_cnt, nomatch_cnt, ovf_cnt, proto_err_cnt}), 128'(0));
   endtask

   initial begin
      #1;
      reset_dut();

      // 4-word match, then single-word packet
      rdy_mode = 0;
      send_pkt(1, 4, 8'h01, 3'd5, 1);
      wait_cyc(6);
      chk("t1_pass", 128'(pass_cnt), 128'(1));
      chk("t1_drained", 128'(exp_q.size()), 128'(0));
      send_pkt(2, 1, 8'h09, 3'd0, 1);
      wait_cyc(4);
      chk("t1b_pass", 128'(pass_cnt), 128'(2));

      // no match, then overflow with ready low, then a small match
      reset_dut();
      send_pkt(1, 4, 8'h00, 3'd5, 0);
      wait_cyc(6);
      chk("t2_nomatch", 128'(nomatch_cnt), 128'(1));
      chk("t2_no_output", 128'(valid_out), 128'(0));
      rdy_mode = 1;
      wait_cyc(1);
      send_pkt(3, 70, 8'h02, 3'd4, 0);
      chk("t3_ovf", 128'(ovf_cnt), 128'(1));
      send_pkt(4, 3, 8'h07, 3'd1, 0);
      wait_cyc(4);
      chk("t3_pass", 128'(pass_cnt), 128'(1));
      rdy_mode = 0;
      wait_cyc(10);
      chk("t3_drained", 128'(exp_q.size()), 128'(0));

      // exactly DEPTH words fit
      reset_dut();
      rdy_mode = 1;
      wait_cyc(1);
      send_pkt(8, DEPTH, 8'h01, 3'd7, 0);
      wait_cyc(4);
      chk("t3b_pass", 128'(pass_cnt), 128'(1));
      chk("t3b_ovf", 128'(ovf_cnt), 128'(0));
      rdy_mode = 0;
      wait_cyc(DEPTH + 8);
      chk("t3b_drained", 128'(exp_q.size()), 128'(0));

      // ready toggling
      reset_dut();
      rdy_mode = 2;
      send_pkt(9, 6, 8'h03, 3'd2, 0);
      wait_cyc(20);
      chk("t4_pass", 128'(pass_cnt), 128'(1));
      chk("t4_drained", 128'(exp_q.size()), 128'(0));

      // protocol errors
      reset_dut();
      rdy_mode = 0;
      drive(1'b1, 1'b0, 3'd0, 64'h1111, 8'h01);
      drive(1'b0, 1'b0, 3'd0, 64'h2222, 8'h01);
      send_pkt(5, 3, 8'h02, 3'd3, 0);
      drive(1'b0, 1'b0, 3'd0, 64'h3333, 8'h01);
      wait_cyc(6);
      chk("t5_proto", 128'(proto_err_cnt), 128'(2));
      chk("t5_pass", 128'(pass_cnt), 128'(1));
      chk("t5_drained", 128'(exp_q.size()), 128'(0));

      // reset with committed-unread and partial packets
      reset_dut();
      rdy_mode = 1;
      wait_cyc(1);
      send_pkt(6, 2, 8'h01, 3'd6, 0);
      drive(1'b1, 1'b0, 3'd0, 64'h4444, 8'h00);
      drive(1'b0, 1'b0, 3'd0, 64'h5555, 8'h00);
      chk("t6_pre_pass", 128'(pass_cnt), 128'(1));
      chk("t6_pre_valid", 128'(valid_out), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 128'(valid_out), 128'(0));
      chk("t6_rst_cnt", 128'({pass_cnt, nomatch_cnt, ovf_cnt, proto_err_cnt}), 128'(0));
      wait_cyc(2);
      rst_n = 1'b1;
      rdy_mode = 0;
      wait_cyc(1);
      send_pkt(7, 3, 8'h04, 3'd2, 1);
      wait_cyc(6);
      chk("t6_pass", 128'(pass_cnt), 128'(1));
      chk("t6_drained", 128'(exp_q.size()), 128'(0));

      // counter saturation on the narrow instance
      reset_dut();
      for (int i = 0; i < 5; i++) drive(1'b0, i[0], 3'd0, 64'(i), 8'h01);
      wait_cyc(2);
      chk("t7_proto", 128'(proto_err_cnt), 128'(5));
      chk("t7_small_sat", 128'(s_proto), 128'(3));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      bad++;
      $display("FAIL watchdog: got timeout want completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
